// File: rtl/int4_dot_accumulator.sv
// ============================================================================
// Module      : int4_dot_accumulator
// Description : Two-stage lane-reduce / accumulate stage for an INT4 MAC row,
//               emitting signed dot-product results through a valid/ready reg.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module int4_dot_accumulator #(
    parameter int LANES = 4,
    parameter int ACC_W = 20,
    parameter int CNT_W = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*8-1:0]   in_prod,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_acc,
    output logic [CNT_W-1:0]     out_beats,
    output logic                 out_ovf
);

    localparam int               c_NPOW      = 1 << $clog2(LANES);
    localparam logic [CNT_W-1:0] c_BEATS_MAX = '1;

    // Stage 1 registers
    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_last_q,  s1_last_d;
    logic [ACC_W-1:0]     s1_sum_q,   s1_sum_d;

    // Stage 2 running state
    logic [ACC_W-1:0]     acc_q,   acc_d;
    logic [CNT_W-1:0]     beats_q, beats_d;
    logic                 ovf_q,   ovf_d;

    // Output register
    logic                 out_valid_q, out_valid_d;
    logic [ACC_W-1:0]     out_acc_q,   out_acc_d;
    logic [CNT_W-1:0]     out_beats_q, out_beats_d;
    logic                 out_ovf_q,   out_ovf_d;

    logic                 w_stall;
    logic                 w_accept;
    logic                 w_commit;
    logic [ACC_W-1:0]     w_lane_sum;
    logic [ACC_W-1:0]     w_nxt;
    logic                 w_ovf_step;
    logic [CNT_W-1:0]     w_beats_inc;
    logic [ACC_W-1:0]     w_node [c_NPOW];

    // Only a last beat can be blocked by a held result; non-last beats never touch the output.
    assign w_stall  = s1_valid_q && s1_last_q && out_valid_q && !out_ready;
    assign in_ready = !w_stall;
    assign w_accept = in_valid && !w_stall;
    assign w_commit = s1_valid_q && !w_stall;

    // Lane reduction: leaves padded to a power of two, summed pairwise level by level.
    always_comb begin
        for (int i = 0; i < c_NPOW; i++) begin
            w_node[i] = '0;
        end
        for (int i = 0; i < LANES; i++) begin
            w_node[i] = ACC_W'($signed(in_prod[8*i +: 8]));
        end
        for (int w = c_NPOW / 2; w >= 1; w = w / 2) begin
            for (int j = 0; j < w; j++) begin
                w_node[j] = w_node[2*j] + w_node[2*j+1];
            end
        end
        w_lane_sum = w_node[0];
    end

    assign w_nxt       = acc_q + s1_sum_q;
    assign w_ovf_step  = (acc_q[ACC_W-1] == s1_sum_q[ACC_W-1]) &&
                         (w_nxt[ACC_W-1] != acc_q[ACC_W-1]);
    assign w_beats_inc = (beats_q == c_BEATS_MAX) ? beats_q : beats_q + 1'b1;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_last_d   = s1_last_q;
        s1_sum_d    = s1_sum_q;
        acc_d       = acc_q;
        beats_d     = beats_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_acc_d   = out_acc_q;
        out_beats_d = out_beats_q;
        out_ovf_d   = out_ovf_q;

        if (!w_stall) begin
            s1_valid_d = w_accept;
            if (w_accept) begin
                s1_last_d = in_last;
                s1_sum_d  = w_lane_sum;
            end
        end

        if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (w_commit) begin
            if (s1_last_q) begin
                out_valid_d = 1'b1;
                out_acc_d   = w_nxt;
                out_beats_d = w_beats_inc;
                out_ovf_d   = ovf_q | w_ovf_step;
                acc_d       = '0;
                beats_d     = '0;
                ovf_d       = 1'b0;
            end else begin
                acc_d   = w_nxt;
                beats_d = w_beats_inc;
                ovf_d   = ovf_q | w_ovf_step;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_sum_q    <= '0;
            acc_q       <= '0;
            beats_q     <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_beats_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_sum_q    <= s1_sum_d;
            acc_q       <= acc_d;
            beats_q     <= beats_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_beats_q <= out_beats_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_beats = out_beats_q;
    assign out_ovf   = out_ovf_q;

endmodule

`default_nettype wire
